// File: rtl/mvu_stream_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : mvu_stream_scoreboard
//  Description : Multi-channel streaming scoreboard. Each channel buffers
//                expected words in a FIFO and compares every accepted actual
//                word against the FIFO head. Global saturating pass/fail
//                counters, sticky first-mismatch capture.
//  Optional    : SCOREBOARD_MASK_EN adds a shared cmp_mask input; only bits
//                set in the mask take part in the compare.
//  Ports       :
//    clk, rst_n            clock, asynchronous active-low reset
//    clr                   synchronous clear of FIFOs, counters and capture
//    exp_valid/data/ready  expected-word push side, one lane per channel
//    act_valid/data/ready  actual-word compare side, one lane per channel
//    cmp_mask              compare mask (SCOREBOARD_MASK_EN builds only)
//    pass_cnt, fail_cnt    saturating totals over all channels
//    ff_vld/ch/idx/exp/act first-fail capture (sticky)
//    busy                  any expected FIFO non-empty
//  Revision    : 1.0 - initial release
// ============================================================================
module mvu_stream_scoreboard #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int CW    = 32,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [NCH-1:0]    exp_valid,
  input  logic [NCH*DW-1:0] exp_data,
  output logic [NCH-1:0]    exp_ready,
  input  logic [NCH-1:0]    act_valid,
  input  logic [NCH*DW-1:0] act_data,
  output logic [NCH-1:0]    act_ready,
`ifdef SCOREBOARD_MASK_EN
  input  logic [DW-1:0]     cmp_mask,
`endif
  output logic [CW-1:0]     pass_cnt,
  output logic [CW-1:0]     fail_cnt,
  output logic              ff_vld,
  output logic [CHW-1:0]    ff_ch,
  output logic [CW-1:0]     ff_idx,
  output logic [DW-1:0]     ff_exp,
  output logic [DW-1:0]     ff_act,
  output logic              busy
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PCW = $clog2(NCH + 1);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PCW-1:0] POP_ONE = PCW'(1);

  logic [NCH-1:0] w_push;
  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_hit;
  logic [NCH-1:0] w_empty;
  logic [DW-1:0]  w_head [NCH];
  logic [CW-1:0]  w_idx  [NCH];

  // --------------------------------------------------------------------------
  // Per-channel expected FIFO and compare index
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_occ;
    logic [CW-1:0] r_idx;
    logic          w_full;
    logic          w_emp;

    assign w_full = (r_occ == OCC_FULL);
    assign w_emp  = (r_occ == '0);

    // Readiness comes only from registered occupancy: a pop in the same
    // cycle never frees a slot for a push, and a push never feeds a compare.
    assign exp_ready[k] = !clr && !w_full;
    assign act_ready[k] = !clr && !w_emp;
    assign w_push[k]    = exp_valid[k] && exp_ready[k];
    assign w_pop[k]     = act_valid[k] && act_ready[k];
    assign w_head[k]    = r_mem[r_rptr];
    assign w_idx[k]     = r_idx;
    assign w_empty[k]   = w_emp;

`ifdef SCOREBOARD_MASK_EN
    assign w_hit[k] = ((w_head[k] ^ act_data[k*DW +: DW]) & cmp_mask) == '0;
`else
    assign w_hit[k] = (w_head[k] == act_data[k*DW +: DW]);
`endif

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
      if (w_push[k]) begin
        r_mem[r_wptr] <= exp_data[k*DW +: DW];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
        r_idx  <= '0;
      end else if (clr) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
        r_idx  <= '0;
      end else begin
        if (w_push[k]) begin
          r_wptr <= r_wptr + PTR_ONE;
        end
        if (w_pop[k]) begin
          r_rptr <= r_rptr + PTR_ONE;
          r_idx  <= r_idx + CNT_ONE;
        end
        if (w_push[k] && !w_pop[k]) begin
          r_occ <= r_occ + OCC_ONE;
        end else if (!w_push[k] && w_pop[k]) begin
          r_occ <= r_occ - OCC_ONE;
        end
      end
    end
  end : g_ch

  // --------------------------------------------------------------------------
  // Cross-channel tally and first-fail selection
  // --------------------------------------------------------------------------
  logic [PCW-1:0] w_npass;
  logic [PCW-1:0] w_nfail;
  logic           w_ff_hit;
  logic [CHW-1:0] w_ff_ch;
  logic [CW-1:0]  w_ff_idx;
  logic [DW-1:0]  w_ff_exp;
  logic [DW-1:0]  w_ff_act;

  always_comb begin
    w_npass  = '0;
    w_nfail  = '0;
    w_ff_hit = 1'b0;
    w_ff_ch  = '0;
    w_ff_idx = '0;
    w_ff_exp = '0;
    w_ff_act = '0;
    // Walk from the highest channel down so the lowest failing channel is
    // the last one written and therefore wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_pop[k]) begin
        if (w_hit[k]) begin
          w_npass = w_npass + POP_ONE;
        end else begin
          w_nfail  = w_nfail + POP_ONE;
          w_ff_hit = 1'b1;
          w_ff_ch  = CHW'(k);
          w_ff_idx = w_idx[k];
          w_ff_exp = w_head[k];
          w_ff_act = act_data[k*DW +: DW];
        end
      end
    end
  end

  // One extra carry bit detects overflow; NCH is far below 2^CW, so a
  // single cycle's increment can never skip past the carry.
  logic [CW:0]   w_pass_sum;
  logic [CW:0]   w_fail_sum;
  logic [CW-1:0] w_pass_next;
  logic [CW-1:0] w_fail_next;

  assign w_pass_sum  = {1'b0, pass_cnt} + (CW + 1)'(w_npass);
  assign w_fail_sum  = {1'b0, fail_cnt} + (CW + 1)'(w_nfail);
  assign w_pass_next = w_pass_sum[CW] ? '1 : w_pass_sum[CW-1:0];
  assign w_fail_next = w_fail_sum[CW] ? '1 : w_fail_sum[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      ff_vld   <= 1'b0;
      ff_ch    <= '0;
      ff_idx   <= '0;
      ff_exp   <= '0;
      ff_act   <= '0;
    end else if (clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      ff_vld   <= 1'b0;
      ff_ch    <= '0;
      ff_idx   <= '0;
      ff_exp   <= '0;
      ff_act   <= '0;
    end else begin
      pass_cnt <= w_pass_next;
      fail_cnt <= w_fail_next;
      if (!ff_vld && w_ff_hit) begin
        ff_vld <= 1'b1;
        ff_ch  <= w_ff_ch;
        ff_idx <= w_ff_idx;
        ff_exp <= w_ff_exp;
        ff_act <= w_ff_act;
      end
    end
  end

  assign busy = ~&w_empty;

endmodule : mvu_stream_scoreboard
`default_nettype wire
